// File: rtl/hazard_pkg.sv
// Shared slot record and default sizing for the hazard scoreboard.
package hazard_pkg;

    localparam int REG_AW_DEF = 4;
    localparam int DEPTH_DEF  = 2;
    localparam int CNT_W_DEF  = 16;

    // Slot destinations are stored at a fixed width so the record can live
    // in the package; narrower register files are zero-extended into it.
    localparam int SB_DEST_W = 8;

    typedef struct packed {
        logic                 valid;
        logic                 wb_en;
        logic                 is_load;
        logic [SB_DEST_W-1:0] dest;
    } sb_slot_t;

endpackage

// File: rtl/hazard_slot_match.sv
// Per-slot RAW comparator: does this in-flight write feed an ID-stage source?
module hazard_slot_match
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
)
(
    input  sb_slot_t          slot,
    input  logic [REG_AW-1:0] src1,
    input  logic [REG_AW-1:0] src2,
    input  logic              two_src,
    output logic              match,
    output logic              load_match
);

    logic hit1;
    logic hit2;

    always_comb begin
        hit1       = (slot.dest == SB_DEST_W'(src1));
        hit2       = two_src && (slot.dest == SB_DEST_W'(src2));
        match      = slot.valid && slot.wb_en && (hit1 || hit2);
        load_match = match && slot.is_load;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight writes with stall request and stall counter.
// HAZARD_FORWARDING_EN: when defined, only a load in slot 0 stalls (load-use).
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = CNT_W_DEF
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] src1,
    input  logic [REG_AW-1:0] src2,
    input  logic              two_src,
    input  logic              id_valid,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              flush,
    output logic              hazard,
    output logic [CNT_W-1:0]  stall_count
);

    sb_slot_t         slots [DEPTH];
    sb_slot_t         slot_in;
    logic [DEPTH-1:0] slot_match;
    logic [DEPTH-1:0] slot_load_match;
    logic             unused_match_bits;

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        hazard_slot_match #(
            .REG_AW (REG_AW)
        ) u_match (
            .slot       (slots[k]),
            .src1       (src1),
            .src2       (src2),
            .two_src    (two_src),
            .match      (slot_match[k]),
            .load_match (slot_load_match[k])
        );
    end

    // Depending on the build, only part of the comparator outputs feed the stall.
    assign unused_match_bits = ^{slot_match, slot_load_match};

`ifdef HAZARD_FORWARDING_EN
    assign hazard = id_valid && slot_load_match[0];
`else
    assign hazard = id_valid && (|slot_match);
`endif

    always_comb begin
        slot_in = '0;
        if (id_valid && !hazard && !flush) begin
            slot_in.valid   = 1'b1;
            slot_in.wb_en   = id_wb_en;
            slot_in.is_load = id_mem_r_en;
            slot_in.dest    = SB_DEST_W'(id_dest);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                slots[k] <= '0;
            end
            stall_count <= '0;
        end else begin
            slots[0] <= slot_in;
            for (int k = 1; k < DEPTH; k++) begin
                slots[k] <= slots[k-1];
            end
            // A flushed instruction is not waiting on anything, so it is not a stall.
            if (hazard && !flush && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: two scoreboard instances (DEPTH=2/CNT_W=4 and DEPTH=3/CNT_W=16) against an issue-age model.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] src1 = '0, src2 = '0, id_dest = '0;
    logic       two_src = 1'b0, id_valid = 1'b0, id_wb_en = 1'b0, id_mem_r_en = 1'b0, flush = 1'b0;
    logic       hazard_a, hazard_b;
    logic [3:0]  stall_count_a;
    logic [15:0] stall_count_b;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_AW(4), .DEPTH(2), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
        .id_valid(id_valid), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .id_dest(id_dest), .flush(flush), .hazard(hazard_a), .stall_count(stall_count_a)
    );

    hazard_scoreboard #(.REG_AW(4), .DEPTH(3), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
        .id_valid(id_valid), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .id_dest(id_dest), .flush(flush), .hazard(hazard_b), .stall_count(stall_count_b)
    );

`ifdef HAZARD_FORWARDING_EN
    localparam int EXP_LU_A = 1;
    localparam int EXP_LU_B = 1;
`else
    localparam int EXP_LU_A = 2;
    localparam int EXP_LU_B = 3;
`endif

    // Model: every issued instruction remembers the cycle it first sits in EXE;
    // its age in the current cycle says which stage it occupies.
    typedef struct {
        int         dut;
        int         enter;
        logic [3:0] dest;
        logic       wb;
        logic       ld;
    } entry_t;

    typedef struct {
        logic ha;
        logic hb;
        int   ca;
        int   cb;
    } expect_t;

    entry_t  inflight[$];
    expect_t expq[$];
    int cyc = 0, cnt_a = 0, cnt_b = 0;
    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic model_hazard(input int dut, input int depth);
        logic h;
        h = 1'b0;
        if (id_valid) begin
            foreach (inflight[i]) begin
                int age;
                age = cyc - inflight[i].enter;
                if (inflight[i].dut == dut && age >= 0 && age < depth && inflight[i].wb &&
                    (inflight[i].dest == src1 || (two_src && inflight[i].dest == src2))) begin
`ifdef HAZARD_FORWARDING_EN
                    if (age == 0 && inflight[i].ld) h = 1'b1;
`else
                    h = 1'b1;
`endif
                end
            end
        end
        return h;
    endfunction

    task automatic admit(input int dut, input logic h);
        entry_t e;
        if (id_valid && !h && !flush) begin
            e.dut = dut; e.enter = cyc + 1; e.dest = id_dest;
            e.wb = id_wb_en; e.ld = id_mem_r_en;
            inflight.push_back(e);
        end
    endtask

    task automatic model_step();
        expect_t e;
        e.ha = model_hazard(0, 2);
        e.hb = model_hazard(1, 3);
        e.ca = cnt_a;
        e.cb = cnt_b;
        expq.push_back(e);
        if (rst) begin
            inflight.delete();
            cnt_a = 0;
            cnt_b = 0;
        end else begin
            admit(0, e.ha);
            admit(1, e.hb);
            if (e.ha && !flush && cnt_a < 15) cnt_a++;
            if (e.hb && !flush && cnt_b < 65535) cnt_b++;
        end
        cyc++;
        while (inflight.size() > 0 && (cyc - inflight[0].enter) >= 3) void'(inflight.pop_front());
    endtask

    task automatic drive(input logic r, input logic v, input logic wb, input logic ld,
                         input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2,
                         input logic ts, input logic fl);
        @(posedge clk);
        #1;
        rst = r; id_valid = v; id_wb_en = wb; id_mem_r_en = ld; id_dest = d;
        src1 = s1; src2 = s2; two_src = ts; flush = fl;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            expect_t e;
            e = expq.pop_front();
            chk("hazard_a", hazard_a, e.ha);
            chk("hazard_b", hazard_b, e.hb);
            chk("stall_count_a", stall_count_a, e.ca);
            chk("stall_count_b", stall_count_b, e.cb);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cap_a, cap_b;

        // Reset
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 4'd3, 4'd3, 1'b1, 1'b0);
        idle(1);
        #2;
        chk("reset_hazard_a", hazard_a, 0);
        chk("reset_count_b", stall_count_b, 0);

        // Load R3, then a dependent add held in ID while stalled
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd4, 4'd3, 4'd1, 1'b1, 1'b0);
        #2;
        chk("loaduse_first_hazard_a", hazard_a, 1);
        chk("loaduse_first_hazard_b", hazard_b, 1);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd4, 4'd3, 4'd1, 1'b1, 1'b0);
        idle(1);
        #2;
        chk("loaduse_count_a", stall_count_a, EXP_LU_A);
        chk("loaduse_count_b", stall_count_b, EXP_LU_B);

        // Non-writing R5, then reader of R5 on an unused src2
        idle(3);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd8, 4'd1, 4'd5, 1'b0, 1'b0);
        #2;
        chk("nowb_hazard_a", hazard_a, 0);
        chk("nowb_hazard_b", hazard_b, 0);

        // Load R7, dependent killed by flush in its stall cycle
        idle(3);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd7, 4'd0, 4'd0, 1'b0, 1'b0);
        cap_a = cnt_a;
        cap_b = cnt_b;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 4'd7, 4'd0, 1'b0, 1'b1);
        #2;
        chk("flush_hazard_a", hazard_a, 1);
        idle(1);
        #2;
        chk("flush_count_a", stall_count_a, cap_a);
        chk("flush_count_b", stall_count_b, cap_b);

        // Saturate the 4-bit counter
        idle(3);
        for (int n = 0; n < 20; n++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0);
            for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 4'd2, 4'd0, 1'b0, 1'b0);
        end
        idle(1);
        #2;
        chk("saturate_count_a", stall_count_a, 15);

        // Reset in the middle of a stall
        idle(3);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd6, 4'd0, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 4'd6, 4'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 4'd6, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 4'd6, 4'd0, 1'b0, 1'b0);
        #2;
        chk("midreset_hazard_a", hazard_a, 0);
        chk("midreset_hazard_b", hazard_b, 0);
        chk("midreset_count_a", stall_count_a, 0);
        chk("midreset_count_b", stall_count_b, 0);

        // Random traffic on a small register set to provoke frequent dependencies
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 49) == 0),
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) == 0),
                  4'($urandom_range(0, 3)),
                  4'($urandom_range(0, 3)),
                  4'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0));
        end
        idle(1);

        for (int i = 0; i < 5 && expq.size() > 0; i++) @(posedge clk);
        if (expq.size() > 0) chk("drain_pending", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised pipeline hazard unit that sits beside the ID stage. It keeps a shift-register scoreboard of in-flight register writes, one slot per stage between ID and write-back. It raises `hazard`, which stalls ID/IF and inserts a bubble, whenever an ID-stage source register depends on an unretired write. With forwarding compiled in, it stalls only on load-use; it also counts stall cycles for performance analysis.

## Interface
Parameters:
- `REG_AW`, 4: register-address width.
- `DEPTH`, 2: in-flight stages tracked. Slot 0 is EXE, slot `DEPTH-1` is the oldest stage before write-back. Legal range is ≥1.
- `CNT_W`, 16: stall-counter width.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `src1`  in  `REG_AW`: first source register of the ID instruction.
- `src2`  in  `REG_AW`: second source register; checked only when `two_src`=1.
- `two_src`  in  1: ID instruction reads `src2`.
- `id_valid`  in  1: ID holds a real instruction, not a bubble.
- `id_wb_en`  in  1: ID instruction writes `id_dest`.
- `id_mem_r_en`  in  1: ID instruction is a load.
- `id_dest`  in  `REG_AW`: destination register of the ID instruction.
- `flush`  in  1: branch taken; the ID instruction is killed this cycle.
- `hazard`  out  1: stall request (combinational).
- `stall_count`  out  `CNT_W`: saturating count of stall cycles.

## Operation
- Each slot holds {valid, wb_en, is_load, dest}.
- A slot k matches when it is valid, has wb_en=1, and either:
  - dest==`src1`, or
  - dest==`src2` with `two_src`=1.
- `hazard` with forwarding (see Configuration) = `id_valid` & slot 0 matches & slot 0 is_load.
- `hazard` without forwarding = `id_valid` & any slot matches.
- On every clock edge, slot k+1 takes slot k for k=0..DEPTH-2, and slot `DEPTH-1` retires.
- Slot 0 loads {1, `id_wb_en`, `id_mem_r_en`, `id_dest`} when `id_valid` & !`hazard` & !`flush`. Otherwise slot 0 loads a bubble (valid=0).
- An instruction with `id_wb_en`=0 still occupies a slot but never matches.
- `stall_count` increments by 1 when `hazard`=1 & `flush`=0. It holds at all-ones once saturated and never wraps.
- `flush` and `hazard` asserted together: `flush` wins. A bubble enters slot 0 and the counter does not increment; `hazard` itself is still driven combinationally.
- `src`==`dest`==0 is compared like any other register; no register is special-cased.

## Timing
- Reset:
  - all slots valid=0 (so `hazard`=0) and `stall_count`=0 on the edge where `rst`=1.
  - `rst` wins over all other inputs.
  - Reset mid-stall drops the stall on the next cycle.
- `hazard` is a zero-latency combinational function of the inputs and slot state.
- Slot and counter updates take effect one cycle after the edge.
- A producer entering slot 0 at edge N is visible to the dependent instruction in ID during cycle N.
- Load-use with forwarding: exactly 1 stall cycle, then the load is in slot 1 and `hazard` drops.
- Without forwarding: a dependent instruction immediately behind its producer stalls `DEPTH` cycles. The stall clears in the cycle the producer leaves slot `DEPTH-1`.
- The stalled ID instruction holds its inputs; the block does not latch them.

## Configuration
- Macro `HAZARD_FORWARDING_EN`.
- Defined: only load-use in slot 0 stalls. All other RAW dependencies are resolved by the forwarding unit.
- Undefined: any matching in-flight write in any slot stalls. `id_mem_r_en` is ignored for the hazard decision, but is still recorded in the slot.

## Structure
- Package `hazard_pkg`:
  - `sb_slot_t` struct typedef {valid, wb_en, is_load, dest}.
  - default localparams for `REG_AW`, `DEPTH`, `CNT_W`.
- Sub-module `hazard_slot_match`: the per-slot comparator. It takes a slot plus `src1`/`src2`/`two_src` and returns match and load-match. It is instantiated `DEPTH` times with a generate loop.
- The top level holds the slot array, the hazard OR-reduction and the counter.

## Test plan
- After reset, R3 ← load, then an add reading R3 as `src1`, with forwarding defined: `hazard`=1 for exactly 1 cycle; `stall_count`=1.
- Same sequence without forwarding, `DEPTH`=2: `hazard`=1 for 2 cycles; `stall_count`=2.
- Writer R5 with `id_wb_en`=0, then a reader of R5 as `src2` with `two_src`=0: `hazard` stays 0 in both configurations.
- Load R7, then a dependent instruction with `flush`=1 in the stall cycle: the bubble enters slot 0 and `stall_count` is unchanged.
- Force 2^`CNT_W`+3 stall cycles with `CNT_W`=4: `stall_count` saturates at 15.
- Assert `rst` during a stall with `DEPTH`=3: the next cycle has `hazard`=0, all slots are empty and `stall_count`=0.
